// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Merges ALU, load and mul/div writeback results into one registered write
// port. Results that cannot retire in their arrival cycle wait in a small
// in-order FIFO, and the FIFO occupancy back-pressures the producers.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          m_valid,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_data,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_data,
    output logic          stall,
    output logic          write,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] data_in,
    output logic          overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage; only entries between the pointers are meaningful.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          write_q, write_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [DW-1:0] data_in_q, data_in_d;
    logic          overflow_q, overflow_d;

    logic          a_v, m_v, md_v, pop;
    logic          push0_v, push1_v, accept0, accept1, drop;
    logic [AW-1:0] push0_addr, push1_addr;
    logic [DW-1:0] push0_data, push1_data;
    logic [CW-1:0] room;

    assign stall    = (count_q >= CW'(DEPTH - 1));
    assign write    = write_q;
    assign w_addr   = w_addr_q;
    assign data_in  = data_in_q;
    assign overflow = overflow_q;

    // Candidate selection: FIFO head first, then A, M, MD; the rest are pushed.
    always_comb begin
        a_v        = a_valid && (a_addr != '0);
        m_v        = m_valid && (m_addr != '0);
        md_ready   = (count_q == '0) && !a_v && !m_v;
        md_v       = md_valid && md_ready && (md_addr != '0);
        pop        = (count_q != '0);
        write_d    = 1'b0;
        w_addr_d   = w_addr_q;
        data_in_d  = data_in_q;
        push0_v    = 1'b0;
        push0_addr = a_addr;
        push0_data = a_data;
        push1_v    = 1'b0;
        push1_addr = m_addr;
        push1_data = m_data;
        if (pop) begin
            write_d   = 1'b1;
            w_addr_d  = addr_mem[rd_ptr_q];
            data_in_d = data_mem[rd_ptr_q];
            if (a_v) begin
                push0_v = 1'b1;
                push1_v = m_v;
            end else if (m_v) begin
                push0_v    = 1'b1;
                push0_addr = m_addr;
                push0_data = m_data;
            end
        end else if (a_v) begin
            write_d    = 1'b1;
            w_addr_d   = a_addr;
            data_in_d  = a_data;
            push0_v    = m_v;
            push0_addr = m_addr;
            push0_data = m_data;
        end else if (m_v) begin
            write_d   = 1'b1;
            w_addr_d  = m_addr;
            data_in_d = m_data;
        end else if (md_v) begin
            write_d   = 1'b1;
            w_addr_d  = md_addr;
            data_in_d = md_data;
        end
        // Free slots after this cycle's pop; pushes beyond that are lost.
        room       = CW'(DEPTH) - count_q + CW'(pop);
        accept0    = push0_v && (room >= CW'(1));
        accept1    = push1_v && (room >= CW'(2));
        drop       = (push0_v && !accept0) || (push1_v && !accept1);
        overflow_d = overflow_q || drop || ((a_v || m_v) && stall);
        count_d    = count_q - CW'(pop) + CW'(accept0) + CW'(accept1);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(accept0) + PW'(accept1);
    end

    // Control state and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            write_q    <= 1'b0;
            w_addr_q   <= '0;
            data_in_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            write_q    <= write_d;
            w_addr_q   <= w_addr_d;
            data_in_q  <= data_in_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO payload writes; the second push lands in the slot after the first.
    always_ff @(posedge clk) begin
        if (accept0) begin
            addr_mem[wr_ptr_q] <= push0_addr;
            data_mem[wr_ptr_q] <= push0_data;
        end
        if (accept1) begin
            addr_mem[wr_ptr_q + PW'(1)] <= push1_addr;
            data_mem[wr_ptr_q + PW'(1)] <= push1_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a table of per-cycle vectors plus a
// hand-written asynchronous reset sequence.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, m_valid = 1'b0, md_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, m_addr = '0, md_addr = '0;
    logic [DW-1:0] a_data = '0, m_data = '0, md_data = '0;
    logic          md_ready, stall, write, overflow;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] data_in;

    regfile_wb_arbiter #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .stall(stall), .write(write), .w_addr(w_addr), .data_in(data_in),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          av;  logic [AW-1:0] aa;  logic [DW-1:0] ad;
        logic          mv;  logic [AW-1:0] ma;  logic [DW-1:0] mdat;
        logic          dv;  logic [AW-1:0] da;  logic [DW-1:0] dd;
        logic          e_rdy; logic e_stall;
        logic          e_wr;  logic [AW-1:0] e_addr; logic [DW-1:0] e_data; logic e_ovf;
    } vec_t;

    vec_t vecs [27];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input logic av, input int aa, input int ad,
                                input logic mv, input int ma, input int mdat,
                                input logic dv, input int da, input int dd,
                                input logic rdy, input logic stl,
                                input logic wr, input int wa, input int wd, input logic ovf);
        vec_t v;
        v.av = av; v.aa = AW'(aa); v.ad = DW'(ad);
        v.mv = mv; v.ma = AW'(ma); v.mdat = DW'(mdat);
        v.dv = dv; v.da = AW'(da); v.dd = DW'(dd);
        v.e_rdy = rdy; v.e_stall = stl;
        v.e_wr = wr; v.e_addr = AW'(wa); v.e_data = DW'(wd); v.e_ovf = ovf;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
        end
    endtask

    task automatic drive_idle();
        a_valid = 0; m_valid = 0; md_valid = 0;
        a_addr = '0; m_addr = '0; md_addr = '0;
        a_data = '0; m_data = '0; md_data = '0;
    endtask

    initial begin
        //            A               M               MD           rdy stl  wr addr data     ovf
        vecs[0]  = mk(1, 3, 'h11,    0, 0, 0,        0, 0, 0,      0, 0,   1, 3,  'h11,  0);
        vecs[1]  = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      1, 0,   0, 3,  'h11,  0);
        vecs[2]  = mk(1, 5, 'hAA,    1, 5, 'hBB,     0, 0, 0,      0, 0,   1, 5,  'hAA,  0);
        vecs[3]  = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      0, 0,   1, 5,  'hBB,  0);
        vecs[4]  = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      1, 0,   0, 5,  'hBB,  0);
        vecs[5]  = mk(1, 0, 'h99,    0, 0, 0,        1, 0, 'h55,   1, 0,   0, 5,  'hBB,  0);
        vecs[6]  = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      1, 0,   0, 5,  'hBB,  0);
        vecs[7]  = mk(1, 1, 'h01,    1, 2, 'h02,     1, 7, 'h77,   0, 0,   1, 1,  'h01,  0);
        vecs[8]  = mk(1, 3, 'h03,    1, 4, 'h04,     1, 7, 'h77,   0, 0,   1, 2,  'h02,  0);
        vecs[9]  = mk(0, 0, 0,       0, 0, 0,        1, 7, 'h77,   0, 0,   1, 3,  'h03,  0);
        vecs[10] = mk(0, 0, 0,       0, 0, 0,        1, 7, 'h77,   0, 0,   1, 4,  'h04,  0);
        vecs[11] = mk(0, 0, 0,       0, 0, 0,        1, 7, 'h77,   1, 0,   1, 7,  'h77,  0);
        vecs[12] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      1, 0,   0, 7,  'h77,  0);
        vecs[13] = mk(1, 8, 'h80,    1, 9, 'h90,     0, 0, 0,      0, 0,   1, 8,  'h80,  0);
        vecs[14] = mk(1, 10, 'hA0,   1, 11, 'hB0,    0, 0, 0,      0, 0,   1, 9,  'h90,  0);
        vecs[15] = mk(1, 12, 'hC0,   1, 13, 'hD0,    0, 0, 0,      0, 0,   1, 10, 'hA0,  0);
        vecs[16] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      0, 1,   1, 11, 'hB0,  0);
        vecs[17] = mk(1, 14, 'hE0,   1, 15, 'hF0,    0, 0, 0,      0, 0,   1, 12, 'hC0,  0);
        vecs[18] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      0, 1,   1, 13, 'hD0,  0);
        vecs[19] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      0, 0,   1, 14, 'hE0,  0);
        vecs[20] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      0, 0,   1, 15, 'hF0,  0);
        vecs[21] = mk(0, 0, 0,       0, 0, 0,        0, 0, 0,      1, 0,   0, 15, 'hF0,  0);
        vecs[22] = mk(1, 16, 'h160,  1, 17, 'h170,   0, 0, 0,      0, 0,   1, 16, 'h160, 0);
        vecs[23] = mk(1, 18, 'h180,  1, 19, 'h190,   0, 0, 0,      0, 0,   1, 17, 'h170, 0);
        vecs[24] = mk(1, 20, 'h200,  1, 21, 'h210,   0, 0, 0,      0, 0,   1, 18, 'h180, 0);
        vecs[25] = mk(1, 22, 'h220,  1, 23, 'h230,   0, 0, 0,      0, 1,   1, 19, 'h190, 1);
        vecs[26] = mk(1, 24, 'h240,  1, 25, 'h250,   0, 0, 0,      0, 1,   1, 20, 'h200, 1);

        drive_idle();
        repeat (2) @(negedge clk);
        // Reset state while rst_n is still low.
        vectors++;
        chk(-1, "reset write", DW'(write), 0);
        chk(-1, "reset w_addr", DW'(w_addr), 0);
        chk(-1, "reset data_in", data_in, 0);
        chk(-1, "reset overflow", DW'(overflow), 0);
        chk(-1, "reset stall", DW'(stall), 0);
        $display("vec -1 reset: write=%0d w_addr=%0d data_in=0x%0h ovf=%0d", write, w_addr, data_in, overflow);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            a_valid = vecs[i].av;  a_addr = vecs[i].aa;  a_data = vecs[i].ad;
            m_valid = vecs[i].mv;  m_addr = vecs[i].ma;  m_data = vecs[i].mdat;
            md_valid = vecs[i].dv; md_addr = vecs[i].da; md_data = vecs[i].dd;
            #1;
            vectors++;
            chk(i, "md_ready", DW'(md_ready), DW'(vecs[i].e_rdy));
            chk(i, "stall", DW'(stall), DW'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            chk(i, "write", DW'(write), DW'(vecs[i].e_wr));
            chk(i, "w_addr", DW'(w_addr), DW'(vecs[i].e_addr));
            chk(i, "data_in", data_in, vecs[i].e_data);
            chk(i, "overflow", DW'(overflow), DW'(vecs[i].e_ovf));
            $display("vec %0d: rdy=%0d stall=%0d -> write=%0d w_addr=%0d data_in=0x%0h ovf=%0d",
                     i, md_ready, stall, write, w_addr, data_in, overflow);
        end

        // Asynchronous reset mid-burst: the FIFO still holds entries here.
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        vectors++;
        chk(27, "rst write", DW'(write), 0);
        chk(27, "rst overflow", DW'(overflow), 0);
        chk(27, "rst stall", DW'(stall), 0);
        chk(27, "rst md_ready", DW'(md_ready), 1);
        $display("vec 27 async reset: write=%0d ovf=%0d stall=%0d md_ready=%0d", write, overflow, stall, md_ready);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        chk(28, "post-rst write", DW'(write), 0);
        $display("vec 28 post reset idle: write=%0d", write);

        // Single result after reset to confirm the FIFO came back empty.
        @(negedge clk);
        a_valid = 1; a_addr = 5'd6; a_data = 32'h66;
        #1;
        vectors++;
        chk(29, "post-rst stall", DW'(stall), 0);
        @(posedge clk);
        #1;
        chk(29, "post-rst write", DW'(write), 1);
        chk(29, "post-rst w_addr", DW'(w_addr), 6);
        chk(29, "post-rst data_in", data_in, 32'h66);
        $display("vec 29 A after reset: write=%0d w_addr=%0d data_in=0x%0h", write, w_addr, data_in);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        vectors++;
        chk(30, "drain write", DW'(write), 0);
        chk(30, "drain overflow", DW'(overflow), 0);
        $display("vec 30 idle: write=%0d ovf=%0d", write, overflow);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
